tstate_seq: RTL and testbench
=============================

// Module: tstate_seq
// PURPOSE
// - Per-cycle timing sequencer downstream of opcode decode: consumes initial_state,
//   single_byte and the read/load/store/rmw memory-pattern flags, steps T-states.
// - Emits address-source select, PC increment, IR load, write enable and result-commit
//   strobes; hands control-flow opcodes (BRK/JSR/RTI/RTS/PHx/PLx/JMP) to the cf sequencer.
// PARAMETERS
// - STATE_W     6  width of T-state code (codes live in cpu_pkg)
// - ADDR_SRC_W  4  width of o_addr_src select
// PORTS
// - i_clk            in   1        clock
// - i_rst            in   1        reset, synchronous, active-high
// - i_rdy            in   1        bus ready; low stalls read cycles
// - i_initial_state  in   STATE_W  first state after T1_DECODE (from decode)
// - i_single_byte    in   1        opcode has no operand byte
// - i_read/i_load    in   1 each   memory pattern flags (valid from T2 to next T0)
// - i_store/i_rmw    in   1 each   memory pattern flags (valid from T2 to next T0)
// - i_carry          in   1        address-adder page carry (indexed EA or branch target)
// - i_cf_done        in   1        control-flow sequencer finished
// - o_state          out  STATE_W  current T-state
// - o_sync           out  1        opcode fetch cycle
// - o_ir_ld          out  1        load IR from data bus at end of cycle
// - o_pc_inc         out  1        increment PC at end of cycle
// - o_addr_src       out  ADDR_SRC_W  ADDR_PC/ZPG/ZPG_IDX/ZPG_IDX1/ABS/ABS_IDX/ABS_FIX/PTR/PTR_IDX/PTR_FIX
// - o_we             out  1        memory write this cycle
// - o_commit         out  1        last cycle of instruction: latch result to res_dst
// - o_cf_start       out  1        one-cycle start pulse to cf sequencer
// - o_jam            out  1        CPU halted in T_JAM
// BEHAVIOUR
// - Reset: state<=T0_FETCH; while i_rst high all strobes (ir_ld,pc_inc,we,commit,cf_start)=0.
// - All outputs combinational from state + inputs; single registered state + ea_src hold reg.
// - T0_FETCH: PC, sync, ir_ld, pc_inc -> T1_DECODE.
// - T1_DECODE: PC, pc_inc=!single_byte; next=i_initial_state; commit=1 if next==T0_FETCH.
// - Access cycle (addr S): load/read: commit -> T0. store: we, commit -> T0.
//   rmw: -> T_RMW_MOD (S, we, unmodified data) -> T_RMW_WR (S, we, commit) -> T0; S held in ea_src.
// - ZPG: T2_ZPG = access(ZPG). Total 3 (rmw 5).
// - ABS: T2_ABS (PC, pc_inc) -> T3_ABS = access(ABS). Total 4.
// - ZPGXY: T2_ZPGXY dummy read ZPG -> T3_ZPGXY = access(ZPG_IDX). Total 4.
// - ABSXY: T2_ABSXY (PC, pc_inc) -> T3_ABSXY read ABS_IDX; if (read|load)&!i_carry = access
//   -> T0; else -> T4_ABSXY = access(ABS_FIX). Stores/rmw always take T4.
// - XIND: T2 dummy ZPG -> T3 ZPG_IDX (ptr lo) -> T4 ZPG_IDX1 (ptr hi) -> T5 access(PTR).
// - INDY: T2 ZPG (ptr lo) -> T3 ZPG+1 (ptr hi) -> T4 PTR_IDX, carry rule as ABSXY -> T5 PTR_FIX.
// - BRANCH: T2_BRANCH (PC): !i_carry -> T0; i_carry -> T3_BRANCH (PC) -> T0. Untaken never enters.
// - Control flow states: -> T_CF, cf_start on entry cycle only; hold until i_cf_done -> T0.
// - Unknown/T_JAM: o_jam=1, state held, strobes 0, exit only via i_rst.
// - i_rdy=0 in a non-write cycle: state held, ir_ld/pc_inc/commit/cf_start suppressed;
//   write cycles (o_we=1) ignore i_rdy. Reset mid-instruction aborts to T0 next edge.
// CONFIGURATION
// - TSEQ_PAGE_SKIP_EN defined: reads/loads with !i_carry skip fix cycle (exact NMOS timing).
// - Undefined: ABSXY/INDY always take fix cycle; data identical, +1 cycle on no-carry reads.
// STRUCTURE
// - cpu_pkg: T-state codes incl. new T3_ABS, T3/T4_ABSXY, T3-T5_XIND, T3-T5_INDY, T_RMW_MOD,
//   T_RMW_WR, T3_BRANCH, T_CF; ADDR_* select enum; shared with decode and datapath.
// - Sub-module tseq_access: combinational access-cycle resolver (mode flags, S -> next, we, commit).
// TESTING
// - LDA zpg (init T2_ZPG, load): T0,T1,T2 -> commit in T2 only, we never high, 3 cycles.
// - INC abs,X rmw carry=0: T0,T1,T2,T3,T4,RMW_MOD,RMW_WR = 7 cycles, we in last 2, commit last.
// - LDA abs,Y carry=0: 4 cycles with TSEQ_PAGE_SKIP_EN, 5 without; carry=1: 5 both.
// - STA (zp),Y carry=0: 6 cycles, we=1 only in T5 (PTR_FIX), rdy=0 there does not stall.
// - Branch taken carry=1: T0,T1,T2_BRANCH,T3_BRANCH,T0; rdy=0 in T1 holds 3 cycles, pc_inc once.
// - JSR: cf_start single pulse, hold T_CF 4 cycles until i_cf_done; i_rst in T_CF -> T0, no strobes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU codes: T-state encodings and address-source selects.
// Used by decode, the T-state sequencer and the datapath.
package cpu_pkg;

    localparam int TSTATE_W = 6;
    localparam int ADDR_W   = 4;

    typedef enum logic [5:0] {
        T0_FETCH   = 6'd0,
        T1_DECODE  = 6'd1,
        T2_ZPG     = 6'd2,
        T2_ABS     = 6'd3,
        T3_ABS     = 6'd4,
        T2_ZPGXY   = 6'd5,
        T3_ZPGXY   = 6'd6,
        T2_ABSXY   = 6'd7,
        T3_ABSXY   = 6'd8,
        T4_ABSXY   = 6'd9,
        T2_XIND    = 6'd10,
        T3_XIND    = 6'd11,
        T4_XIND    = 6'd12,
        T5_XIND    = 6'd13,
        T2_INDY    = 6'd14,
        T3_INDY    = 6'd15,
        T4_INDY    = 6'd16,
        T5_INDY    = 6'd17,
        T_RMW_MOD  = 6'd18,
        T_RMW_WR   = 6'd19,
        T2_BRANCH  = 6'd20,
        T3_BRANCH  = 6'd21,
        T2_BRK     = 6'd22,
        T2_JSR     = 6'd23,
        T2_RTI     = 6'd24,
        T2_RTS     = 6'd25,
        T2_PHX     = 6'd26,
        T2_PLX     = 6'd27,
        T2_JMP     = 6'd28,
        T_CF       = 6'd29,
        T_JAM      = 6'd63
    } tstate_t;

    // ADDR_ZPG1 is the zero-page pointer high byte for (zp),Y.
    typedef enum logic [3:0] {
        ADDR_PC       = 4'd0,
        ADDR_ZPG      = 4'd1,
        ADDR_ZPG_IDX  = 4'd2,
        ADDR_ZPG_IDX1 = 4'd3,
        ADDR_ABS      = 4'd4,
        ADDR_ABS_IDX  = 4'd5,
        ADDR_ABS_FIX  = 4'd6,
        ADDR_PTR      = 4'd7,
        ADDR_PTR_IDX  = 4'd8,
        ADDR_PTR_FIX  = 4'd9,
        ADDR_ZPG1     = 4'd10
    } addr_src_t;

endpackage

// File: rtl/tseq_access.sv
// Access-cycle resolver: maps the memory-pattern flags of the
// current opcode onto next state, write enable and commit.
module tseq_access
    import cpu_pkg::*;
(
    input  logic    read,
    input  logic    load,
    input  logic    store,
    input  logic    rmw,
    output tstate_t next,
    output logic    we,
    output logic    commit
);

    always_comb begin
        next   = T0_FETCH;
        we     = 1'b0;
        commit = 1'b0;
        if (rmw) begin
            next = T_RMW_MOD;
        end else if (store) begin
            we     = 1'b1;
            commit = 1'b1;
        end else begin
            commit = read | load;
        end
    end

endmodule

// File: rtl/tstate_seq.sv
// Per-cycle T-state sequencer. Define TSEQ_PAGE_SKIP_EN to let
// no-carry indexed reads skip the page-fix cycle.
module tstate_seq
    import cpu_pkg::*;
#(
    parameter int STATE_W    = TSTATE_W,
    parameter int ADDR_SRC_W = ADDR_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rdy,
    input  logic [STATE_W-1:0]    i_initial_state,
    input  logic                  i_single_byte,
    input  logic                  i_read,
    input  logic                  i_load,
    input  logic                  i_store,
    input  logic                  i_rmw,
    input  logic                  i_carry,
    input  logic                  i_cf_done,
    output logic [STATE_W-1:0]    o_state,
    output logic                  o_sync,
    output logic                  o_ir_ld,
    output logic                  o_pc_inc,
    output logic [ADDR_SRC_W-1:0] o_addr_src,
    output logic                  o_we,
    output logic                  o_commit,
    output logic                  o_cf_start,
    output logic                  o_jam
);

    tstate_t   state, nxt, a_next;
    addr_src_t src, acc_src, ea_src;
    logic      acc, skip, hold, a_we, a_commit;
    logic      sync, ir_ld, pc_inc, we, commit, cf_start, jam;

    tseq_access u_access (
        .read   (i_read),
        .load   (i_load),
        .store  (i_store),
        .rmw    (i_rmw),
        .next   (a_next),
        .we     (a_we),
        .commit (a_commit)
    );

`ifdef TSEQ_PAGE_SKIP_EN
    assign skip = (i_read | i_load) & ~i_carry;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= T0_FETCH;
            ea_src <= ADDR_PC;
        end else begin
            state <= nxt;
            if (acc && !hold)
                ea_src <= acc_src;
        end
    end

    always_comb begin
        nxt      = state;
        src      = ADDR_PC;
        acc      = 1'b0;
        acc_src  = ADDR_PC;
        sync     = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        we       = 1'b0;
        commit   = 1'b0;
        cf_start = 1'b0;
        jam      = 1'b0;
        case (state)
            T0_FETCH: begin
                sync   = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
                nxt    = T1_DECODE;
            end
            T1_DECODE: begin
                pc_inc = ~i_single_byte;
                nxt    = tstate_t'(i_initial_state);
                commit = (nxt == T0_FETCH);
            end
            T2_ZPG:   begin acc = 1'b1; acc_src = ADDR_ZPG; end
            T2_ABS:   begin pc_inc = 1'b1; nxt = T3_ABS; end
            T3_ABS:   begin acc = 1'b1; acc_src = ADDR_ABS; end
            T2_ZPGXY: begin src = ADDR_ZPG; nxt = T3_ZPGXY; end
            T3_ZPGXY: begin acc = 1'b1; acc_src = ADDR_ZPG_IDX; end
            T2_ABSXY: begin pc_inc = 1'b1; nxt = T3_ABSXY; end
            T3_ABSXY: begin
                acc_src = ADDR_ABS_IDX;
                acc     = skip;
                src     = ADDR_ABS_IDX;
                nxt     = T4_ABSXY;
            end
            T4_ABSXY: begin acc = 1'b1; acc_src = ADDR_ABS_FIX; end
            T2_XIND:  begin src = ADDR_ZPG; nxt = T3_XIND; end
            T3_XIND:  begin src = ADDR_ZPG_IDX; nxt = T4_XIND; end
            T4_XIND:  begin src = ADDR_ZPG_IDX1; nxt = T5_XIND; end
            T5_XIND:  begin acc = 1'b1; acc_src = ADDR_PTR; end
            T2_INDY:  begin src = ADDR_ZPG; nxt = T3_INDY; end
            T3_INDY:  begin src = ADDR_ZPG1; nxt = T4_INDY; end
            T4_INDY: begin
                acc_src = ADDR_PTR_IDX;
                acc     = skip;
                src     = ADDR_PTR_IDX;
                nxt     = T5_INDY;
            end
            T5_INDY:  begin acc = 1'b1; acc_src = ADDR_PTR_FIX; end
            // Modify cycle rewrites the unmodified operand, as NMOS does.
            T_RMW_MOD: begin src = ea_src; we = 1'b1; nxt = T_RMW_WR; end
            T_RMW_WR: begin
                src    = ea_src;
                we     = 1'b1;
                commit = 1'b1;
                nxt    = T0_FETCH;
            end
            T2_BRANCH: nxt = i_carry ? T3_BRANCH : T0_FETCH;
            T3_BRANCH: nxt = T0_FETCH;
            T2_BRK, T2_JSR, T2_RTI, T2_RTS,
            T2_PHX, T2_PLX, T2_JMP: begin
                cf_start = 1'b1;
                nxt      = T_CF;
            end
            T_CF: begin
                if (i_cf_done) begin
                    commit = 1'b1;
                    nxt    = T0_FETCH;
                end
            end
            default: jam = 1'b1;
        endcase
        if (acc) begin
            src    = acc_src;
            nxt    = a_next;
            we     = a_we;
            commit = a_commit;
        end
        hold = ~i_rdy & ~we;
        if (hold) begin
            nxt      = state;
            ir_ld    = 1'b0;
            pc_inc   = 1'b0;
            commit   = 1'b0;
            cf_start = 1'b0;
        end
        if (i_rst) begin
            nxt      = T0_FETCH;
            ir_ld    = 1'b0;
            pc_inc   = 1'b0;
            we       = 1'b0;
            commit   = 1'b0;
            cf_start = 1'b0;
        end
    end

    assign o_state    = STATE_W'(state);
    assign o_addr_src = ADDR_SRC_W'(src);
    assign o_sync     = sync;
    assign o_ir_ld    = ir_ld;
    assign o_pc_inc   = pc_inc;
    assign o_we       = we;
    assign o_commit   = commit;
    assign o_cf_start = cf_start;
    assign o_jam      = jam;

endmodule

// File: tb/tb_tstate_seq.sv
// Directed bench for tstate_seq: walks addressing modes cycle by
// cycle against hand-computed states and strobes.
module tb_tstate_seq;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst, rdy, sb, rd, ld, st, rmw, carry, cfd;
    logic [5:0] init;
    logic [5:0] o_state;
    logic [3:0] o_addr_src;
    logic       o_sync, o_ir_ld, o_pc_inc, o_we, o_commit;
    logic       o_cf_start, o_jam;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    tstate_seq dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rdy           (rdy),
        .i_initial_state (init),
        .i_single_byte   (sb),
        .i_read          (rd),
        .i_load          (ld),
        .i_store         (st),
        .i_rmw           (rmw),
        .i_carry         (carry),
        .i_cf_done       (cfd),
        .o_state         (o_state),
        .o_sync          (o_sync),
        .o_ir_ld         (o_ir_ld),
        .o_pc_inc        (o_pc_inc),
        .o_addr_src      (o_addr_src),
        .o_we            (o_we),
        .o_commit        (o_commit),
        .o_cf_start      (o_cf_start),
        .o_jam           (o_jam)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks one cycle, then advances to 1 time unit past the next edge.
    task automatic cyc(input string tag, input tstate_t s,
                       input addr_src_t a, input logic pi,
                       input logic w, input logic cm, input logic cs);
        #1;
        chk({tag, ".state"}, 32'(o_state), 32'(s));
        chk({tag, ".addr"}, 32'(o_addr_src), 32'(a));
        chk({tag, ".pc_inc"}, 32'(o_pc_inc), 32'(pi));
        chk({tag, ".we"}, 32'(o_we), 32'(w));
        chk({tag, ".commit"}, 32'(o_commit), 32'(cm));
        chk({tag, ".cf_start"}, 32'(o_cf_start), 32'(cs));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; rdy = 1; sb = 0; rd = 0; ld = 0; st = 0;
        rmw = 0; carry = 0; cfd = 0; init = T0_FETCH;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.state", 32'(o_state), 32'(T0_FETCH));
        chk("rst.ir_ld", 32'(o_ir_ld), 32'd0);
        chk("rst.pc_inc", 32'(o_pc_inc), 32'd0);
        chk("rst.commit", 32'(o_commit), 32'd0);
        @(posedge clk);
        #1;

        // LDA zpg
        rst = 0; init = T2_ZPG; ld = 1;
        #1;
        chk("t0.ir_ld", 32'(o_ir_ld), 32'd1);
        chk("t0.sync", 32'(o_sync), 32'd1);
        cyc("lda_zpg.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("lda_zpg.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("lda_zpg.t2", T2_ZPG, ADDR_ZPG, 0, 0, 1, 0);

        // INC abs,X
        ld = 0; rmw = 1; carry = 0; init = T2_ABSXY;
        cyc("inc.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("inc.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("inc.t2", T2_ABSXY, ADDR_PC, 1, 0, 0, 0);
        cyc("inc.t3", T3_ABSXY, ADDR_ABS_IDX, 0, 0, 0, 0);
        cyc("inc.t4", T4_ABSXY, ADDR_ABS_FIX, 0, 0, 0, 0);
        cyc("inc.mod", T_RMW_MOD, ADDR_ABS_FIX, 0, 1, 0, 0);
        cyc("inc.wr", T_RMW_WR, ADDR_ABS_FIX, 0, 1, 1, 0);

        // LDA abs,Y, no page carry
        rmw = 0; ld = 1; init = T2_ABSXY;
        cyc("ldy0.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("ldy0.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("ldy0.t2", T2_ABSXY, ADDR_PC, 1, 0, 0, 0);
`ifdef TSEQ_PAGE_SKIP_EN
        cyc("ldy0.t3", T3_ABSXY, ADDR_ABS_IDX, 0, 0, 1, 0);
`else
        cyc("ldy0.t3", T3_ABSXY, ADDR_ABS_IDX, 0, 0, 0, 0);
        cyc("ldy0.t4", T4_ABSXY, ADDR_ABS_FIX, 0, 0, 1, 0);
`endif

        // LDA abs,Y, page carry
        carry = 1;
        cyc("ldy1.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("ldy1.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("ldy1.t2", T2_ABSXY, ADDR_PC, 1, 0, 0, 0);
        cyc("ldy1.t3", T3_ABSXY, ADDR_ABS_IDX, 0, 0, 0, 0);
        cyc("ldy1.t4", T4_ABSXY, ADDR_ABS_FIX, 0, 0, 1, 0);

        // STA (zp),Y with rdy low in the write cycle
        ld = 0; st = 1; carry = 0; init = T2_INDY;
        cyc("sta.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("sta.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("sta.t2", T2_INDY, ADDR_ZPG, 0, 0, 0, 0);
        cyc("sta.t3", T3_INDY, ADDR_ZPG1, 0, 0, 0, 0);
        cyc("sta.t4", T4_INDY, ADDR_PTR_IDX, 0, 0, 0, 0);
        rdy = 0;
        cyc("sta.t5", T5_INDY, ADDR_PTR_FIX, 0, 1, 1, 0);
        rdy = 1;

        // Taken branch with page carry, rdy stall in T1
        st = 0; carry = 1; init = T2_BRANCH;
        cyc("br.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        rdy = 0;
        cyc("br.t1a", T1_DECODE, ADDR_PC, 0, 0, 0, 0);
        cyc("br.t1b", T1_DECODE, ADDR_PC, 0, 0, 0, 0);
        rdy = 1;
        cyc("br.t1c", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("br.t2", T2_BRANCH, ADDR_PC, 0, 0, 0, 0);
        cyc("br.t3", T3_BRANCH, ADDR_PC, 0, 0, 0, 0);

        // JSR handed to the control-flow sequencer
        carry = 0; init = T2_JSR;
        cyc("jsr.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("jsr.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("jsr.t2", T2_JSR, ADDR_PC, 0, 0, 0, 1);
        cyc("jsr.cf1", T_CF, ADDR_PC, 0, 0, 0, 0);
        cyc("jsr.cf2", T_CF, ADDR_PC, 0, 0, 0, 0);
        cyc("jsr.cf3", T_CF, ADDR_PC, 0, 0, 0, 0);
        cfd = 1;
        cyc("jsr.cf4", T_CF, ADDR_PC, 0, 0, 1, 0);
        cfd = 0;

        // JSR aborted by reset inside T_CF
        cyc("jsr2.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("jsr2.t1", T1_DECODE, ADDR_PC, 1, 0, 0, 0);
        cyc("jsr2.t2", T2_JSR, ADDR_PC, 0, 0, 0, 1);
        cfd = 1; rst = 1;
        #1;
        chk("jsr2.rst.state", 32'(o_state), 32'(T_CF));
        chk("jsr2.rst.commit", 32'(o_commit), 32'd0);
        chk("jsr2.rst.cf_start", 32'(o_cf_start), 32'd0);
        chk("jsr2.rst.we", 32'(o_we), 32'd0);
        @(posedge clk);
        #2;
        chk("jsr2.abort.state", 32'(o_state), 32'(T0_FETCH));
        chk("jsr2.abort.ir_ld", 32'(o_ir_ld), 32'd0);
        chk("jsr2.abort.pc_inc", 32'(o_pc_inc), 32'd0);
        @(posedge clk);
        #1;
        rst = 0; cfd = 0;

        // Single-byte implied opcode commits in T1
        sb = 1; init = T0_FETCH;
        cyc("imp.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("imp.t1", T1_DECODE, ADDR_PC, 0, 0, 1, 0);

        // JAM holds until reset
        init = T_JAM;
        cyc("jam.t0", T0_FETCH, ADDR_PC, 1, 0, 0, 0);
        cyc("jam.t1", T1_DECODE, ADDR_PC, 0, 0, 0, 0);
        #1;
        chk("jam.flag", 32'(o_jam), 32'd1);
        chk("jam.state", 32'(o_state), 32'(T_JAM));
        rd = 1; st = 1; cfd = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("jam.held", 32'(o_state), 32'(T_JAM));
        chk("jam.we", 32'(o_we), 32'd0);
        chk("jam.commit", 32'(o_commit), 32'd0);
        rst = 1;
        @(posedge clk);
        #2;
        chk("jam.exit", 32'(o_state), 32'(T0_FETCH));
        chk("jam.clear", 32'(o_jam), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
